// File: rtl/score_display_ctrl_pkg.sv
// Shared types and the 7-segment encoder for the snake scoreboard.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_e;

  typedef logic [1:0] digit_sel_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter: one load cycle, then seven
// add-3/shift cycles. Start is ignored while a conversion is running.
module bin2bcd_seq (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  // {tens, units, remaining binary bits}
  logic [14:0] sreg;
  logic [14:0] sreg_next;
  logic [2:0]  step_cnt;

  function automatic logic [14:0] dabble(input logic [14:0] s);
    logic [14:0] a;
    a = s;
    if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7]  + 4'd3;
    if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
    return {a[13:0], 1'b0};
  endfunction

  assign sreg_next = dabble(sreg);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      step_cnt <= 3'd0;
      sreg     <= 15'd0;
      tens_o   <= 4'd0;
      units_o  <= 4'd0;
    end else begin
      done_o <= 1'b0;
      if (!busy_o) begin
        if (start_i) begin
          busy_o   <= 1'b1;
          step_cnt <= 3'd0;
          sreg     <= {8'd0, bin_i};
        end
      end else begin
        sreg     <= sreg_next;
        step_cnt <= step_cnt + 3'd1;
        if (step_cnt == 3'd6) begin
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          tens_o  <= sreg_next[14:11];
          units_o <= sreg_next[10:7];
        end
      end
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Snake scoreboard: game FSM, score/high-score registers with apple prescale,
// shared BCD conversion and a 4-digit multiplexed 7-segment display with blink.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int APPLES_PER_POINT = 5,
  parameter int MAX_SCORE        = 99,
  parameter int SCAN_DIV         = 50000,
  parameter int BLINK_TICKS      = 250
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       apple_colline,
  input  logic       game_start_i,
  input  logic       game_over_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic [6:0] score_o,
  output logic [6:0] hi_score_o,
  output logic       new_record_o
);

  localparam int AW = (APPLES_PER_POINT > 1) ? $clog2(APPLES_PER_POINT) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  game_state_e   state;
  logic [AW-1:0] apple_cnt;
  logic          apple_en, apple_wrap, enter_over, do_start;
  logic [6:0]    next_score, score_n, hi_n;

  logic          pend_s, pend_h, conv_is_hi;
  logic          conv_start, conv_hi, conv_busy, conv_done;
  logic [6:0]    conv_bin;
  logic [3:0]    conv_tens, conv_units;
  logic [3:0]    s_tens, s_units, h_tens, h_units;

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_off, tick, slot_blank;
  digit_sel_t    slot;
  logic [3:0]    slot_digit;

  always_comb begin
    apple_en   = (state == PLAY) && apple_colline && (score_o < 7'(MAX_SCORE));
    apple_wrap = apple_en && (apple_cnt == AW'(APPLES_PER_POINT - 1));
    next_score = score_o + {6'd0, apple_wrap};
    enter_over = (state == PLAY) && game_over_i;
    do_start   = (state != PLAY) && game_start_i;
    score_n    = do_start ? 7'd0 : next_score;
    hi_n       = (enter_over && (next_score > hi_score_o)) ? next_score : hi_score_o;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      apple_cnt    <= '0;
      score_o      <= 7'd0;
      hi_score_o   <= 7'd0;
      new_record_o <= 1'b0;
    end else begin
      score_o    <= score_n;
      hi_score_o <= hi_n;
      case (state)
        IDLE, OVER: begin
          if (game_start_i) begin
            state        <= PLAY;
            apple_cnt    <= '0;
            new_record_o <= 1'b0;
          end
        end
        PLAY: begin
          if (apple_en) apple_cnt <= apple_wrap ? '0 : apple_cnt + AW'(1);
          if (game_over_i) begin
            state <= OVER;
            if (next_score > hi_score_o) new_record_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Score has priority over hi for the shared converter.
  always_comb begin
    conv_start = !conv_busy && (pend_s || pend_h);
    conv_hi    = !pend_s;
    conv_bin   = conv_hi ? hi_score_o : score_o;
  end

  bin2bcd_seq u_bcd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .tens_o  (conv_tens),
    .units_o (conv_units)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_s     <= 1'b0;
      pend_h     <= 1'b0;
      conv_is_hi <= 1'b0;
      s_tens     <= 4'd0;
      s_units    <= 4'd0;
      h_tens     <= 4'd0;
      h_units    <= 4'd0;
    end else begin
      pend_s <= (pend_s && !(conv_start && !conv_hi)) || (score_n != score_o);
      pend_h <= (pend_h && !(conv_start && conv_hi)) || (hi_n != hi_score_o);
      if (conv_start) conv_is_hi <= conv_hi;
      if (conv_done) begin
        if (conv_is_hi) begin
          h_tens  <= conv_tens;
          h_units <= conv_units;
        end else begin
          s_tens  <= conv_tens;
          s_units <= conv_units;
        end
      end
    end
  end

  always_comb begin
    tick = (scan_cnt == SW'(SCAN_DIV - 1));
    case (slot)
      2'd0:    slot_digit = s_units;
      2'd1:    slot_digit = s_tens;
      2'd2:    slot_digit = h_units;
      default: slot_digit = h_tens;
    endcase
    slot_blank = !slot[1] && ((state == IDLE) || ((state == OVER) && blink_off));
  end

  // Display registers latch the current slot on each tick, then advance it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scan_cnt  <= '0;
      slot      <= 2'd0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      an_o      <= 4'b1111;
      seg_o     <= SEG_BLANK;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + SW'(1);
      if (tick) begin
        slot  <= slot + 2'd1;
        an_o  <= ~(4'b0001 << slot);
        seg_o <= slot_blank ? SEG_BLANK : seg_encode(slot_digit);
      end
      if (enter_over) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          blink_off <= !blink_off;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a score scoreboard and
// display/blink checks against a reference segment table.
module tb_score_display_ctrl;

  localparam int APP  = 5;
  localparam int MAXS = 99;
  localparam int SD   = 4;
  localparam int BT   = 2;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       apple_colline = 1'b0;
  logic       game_start_i = 1'b0;
  logic       game_over_i = 1'b0;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic [6:0] score_o;
  logic [6:0] hi_score_o;
  logic       new_record_o;

  always #5 clk = ~clk;

  score_display_ctrl #(
    .APPLES_PER_POINT (APP),
    .MAX_SCORE        (MAXS),
    .SCAN_DIV         (SD),
    .BLINK_TICKS      (BT)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .apple_colline(apple_colline),
    .game_start_i (game_start_i),
    .game_over_i  (game_over_i),
    .seg_o        (seg_o),
    .an_o         (an_o),
    .score_o      (score_o),
    .hi_score_o   (hi_score_o),
    .new_record_o (new_record_o)
  );

  int errors = 0;
  int checks = 0;

  int m_score = 0, m_cnt = 0, m_hi = 0;
  bit m_play = 0, m_rec = 0;
  logic [6:0] sb[$];

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    game_start_i = 1'b1;
    m_score = 0; m_cnt = 0; m_rec = 0; m_play = 1;
    step();
    game_start_i = 1'b0;
    chk("start_score", score_o, 0);
    chk("start_rec", new_record_o, 0);
  endtask

  task automatic apple(input bit with_over);
    logic [6:0] exp;
    apple_colline = 1'b1;
    game_over_i   = with_over;
    if (m_play && m_score < MAXS) begin
      m_cnt++;
      if (m_cnt == APP) begin
        m_cnt = 0;
        m_score++;
      end
    end
    if (with_over && m_play) begin
      m_play = 0;
      if (m_score > m_hi) begin
        m_hi  = m_score;
        m_rec = 1;
      end
    end
    sb.push_back(7'(m_score));
    step();
    apple_colline = 1'b0;
    game_over_i   = 1'b0;
    exp = sb.pop_front();
    chk("score", score_o, exp);
    if (with_over) begin
      chk("over_hi", hi_score_o, m_hi);
      chk("over_rec", new_record_o, m_rec);
    end
  endtask

  task automatic apples(input int n);
    for (int i = 0; i < n; i++) apple(1'b0);
  endtask

  task automatic end_game();
    game_over_i = 1'b1;
    if (m_play) begin
      m_play = 0;
      if (m_score > m_hi) begin
        m_hi  = m_score;
        m_rec = 1;
      end
    end
    step();
    game_over_i = 1'b0;
    chk("end_hi", hi_score_o, m_hi);
    chk("end_rec", new_record_o, m_rec);
    chk("end_score", score_o, m_score);
  endtask

  // Let conversions settle, then check a freshly refreshed slot.
  task automatic show(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    logic [3:0] prev;
    bit found;
    found = 0;
    for (int i = 0; i < 16; i++) step();
    prev = an_o;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (an_o != prev && an_o == an_exp) found = 1;
      prev = an_o;
    end
    chk({tag, "_found"}, found, 1);
    if (found) chk(tag, seg_o, seg_exp);
  endtask

  task automatic expect_next(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    logic [3:0] prev;
    bit changed;
    changed = 0;
    prev = an_o;
    for (int i = 0; i < 3 * SD && !changed; i++) begin
      step();
      if (an_o != prev) changed = 1;
    end
    chk({tag, "_an"}, an_o, an_exp);
    chk({tag, "_seg"}, seg_o, seg_exp);
  endtask

  task automatic blink_check(input string tag, input int su, input int st, input int hu, input int ht);
    logic [3:0] prev;
    int n, slot, dig;
    bit vis;
    prev = an_o;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
      step();
      if (an_o != prev) begin
        n++;
        prev = an_o;
        case (an_o)
          4'b1110: begin slot = 0; dig = su; end
          4'b1101: begin slot = 1; dig = st; end
          4'b1011: begin slot = 2; dig = hu; end
          4'b0111: begin slot = 3; dig = ht; end
          default: begin slot = -1; dig = 0; end
        endcase
        chk({tag, "_an_onehot"}, (slot >= 0), 1);
        vis = (slot >= 2) || ((((n - 1) / BT) % 2) == 0);
        if (!vis)        chk({tag, "_blank"}, seg_o, 7'h7F);
        else if (n >= 8) chk({tag, "_digit"}, seg_o, enc(dig));
        else             chk({tag, "_lit"}, (seg_o != 7'h7F), 1);
      end
    end
    chk({tag, "_ticks"}, n, 16);
  endtask

  initial begin
    bit seen;
    repeat (3) step();
    chk("rst_an", an_o, 4'b1111);
    chk("rst_seg", seg_o, 7'h7F);
    chk("rst_score", score_o, 0);
    chk("rst_hi", hi_score_o, 0);
    chk("rst_rec", new_record_o, 0);
    reset_i = 1'b0;

    // Idle scan order and blanking of score slots
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (an_o == 4'b0111) seen = 1;
    end
    chk("idle_scan_seen", seen, 1);
    expect_next("idle_s0", 4'b1110, 7'h7F);
    expect_next("idle_s1", 4'b1101, 7'h7F);
    expect_next("idle_s2", 4'b1011, enc(0));
    expect_next("idle_s3", 4'b0111, enc(0));

    // Prescale: 4 apples hold at 0, 5th scores a point
    start_game();
    apples(4);
    apple(1'b0);
    show("play_s0_one", 4'b1110, enc(1));
    end_game();

    // Score 7 then the 5th apple lands together with game over
    start_game();
    apples(39);
    apple(1'b1);
    blink_check("over8", 8, 0, 8, 0);

    // Lower score: high score kept, no record
    start_game();
    apples(15);
    end_game();
    blink_check("over3", 3, 0, 8, 0);

    // Saturation at 99
    start_game();
    apples(500);
    show("sat_s0", 4'b1110, enc(9));
    show("sat_s1", 4'b1101, enc(9));

    // Reset during PLAY with a high-score conversion in flight
    end_game();
    step();
    step();
    start_game();
    step();
    reset_i = 1'b1;
    step();
    chk("mid_rst_an", an_o, 4'b1111);
    chk("mid_rst_seg", seg_o, 7'h7F);
    chk("mid_rst_score", score_o, 0);
    chk("mid_rst_hi", hi_score_o, 0);
    chk("mid_rst_rec", new_record_o, 0);
    reset_i = 1'b0;
    m_score = 0; m_cnt = 0; m_hi = 0; m_play = 0; m_rec = 0;
    sb.delete();
    show("post_rst_h0", 4'b1011, enc(0));
    show("post_rst_h1", 4'b0111, enc(0));
    show("post_rst_s0", 4'b1110, 7'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
